// File: rtl/riscv_csr_counters_pkg.sv
// Shared definitions for the counter/timer CSR unit: CSR addresses, CSR
// operation encoding, counter index layout and the mcountinhibit write mask.
package riscv_csr_counters_pkg;

   typedef enum logic [11:0] {
      CSR_MCOUNTINHIBIT = 12'h320,
      CSR_MCYCLE        = 12'hB00,
      CSR_MINSTRET      = 12'hB02,
      CSR_MHPMCOUNTER3  = 12'hB03,
      CSR_MCYCLEH       = 12'hB80,
      CSR_MINSTRETH     = 12'hB82,
      CSR_MHPMCOUNTER3H = 12'hB83,
      CSR_CYCLE         = 12'hC00,
      CSR_HPMCOUNTER3   = 12'hC03,
      CSR_HPMCOUNTER3H  = 12'hC83
   } csr_address_e;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_e;

   localparam int CYCLE_IDX    = 0;
   localparam int TIME_IDX     = 1;
   localparam int INSTRET_IDX  = 2;
   localparam int HPM_BASE_IDX = 3;

   // Keeps the top nibble and bits [6:5]; bit 7 selects lo/hi and bits [4:0]
   // select the counter, so every counter alias collapses onto its base.
   localparam logic [11:0] CNT_RANGE_MASK = 12'hF60;

   // mcountinhibit: bit 0 (cycle) and bits [2+num_hpm:2] are implemented.
   function automatic logic [31:0] inhibit_mask(input int num_hpm);
      logic [31:0] m;
      m = 32'h1;
      for (int i = 0; i <= num_hpm; i++) m[2+i] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/riscv_csr_counters_counter64.sv
// riscv_counter64: one wide counter with 32-bit half writes.
// Ports: clk, rst_n (sync, active-low), inc (count this cycle),
// wr_lo / wr_hi (replace low / high half with wdata), value (count).
// A write to either half blocks the increment for the whole counter, so
// there is never a carry into the half that was not written.
module riscv_counter64 #(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inc,
   input  logic                 wr_lo,
   input  logic                 wr_hi,
   input  logic [31:0]          wdata,
   output logic [CNT_WIDTH-1:0] value
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value <= '0;
      end else if (wr_lo || wr_hi) begin
         if (wr_lo) value[31:0] <= wdata;
         if (wr_hi) value[CNT_WIDTH-1:32] <= wdata[CNT_WIDTH-33:0];
      end else if (inc) begin
         value <= value + 1'b1;
      end
   end

endmodule

// File: rtl/riscv_csr_counters.sv
// riscv_csr_counters: cycle/time/instret and NUM_HPM performance counters
// with their user read-only and machine read/write CSR aliases, plus
// mcountinhibit. One CSR access per cycle; the old value is returned one
// cycle later on csr_rdata with csr_rvalid.
// Ports: clk, rst_n (sync, active-low); csr_en/csr_addr/csr_op/csr_wdata
// (access request); csr_rvalid/csr_rdata/csr_illegal (registered response);
// instr_retired, hpm_event[NUM_HPM] (increment sources).
module riscv_csr_counters
   import riscv_csr_counters_pkg::*;
#(
   parameter int NUM_HPM   = 4,
   parameter int TIME_DIV  = 1,
   parameter int CNT_WIDTH = 64
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 csr_en,
   input  logic [11:0]                          csr_addr,
   input  logic [1:0]                           csr_op,
   input  logic [31:0]                          csr_wdata,
   output logic                                 csr_rvalid,
   output logic [31:0]                          csr_rdata,
   output logic                                 csr_illegal,
   input  logic                                 instr_retired,
   input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event
);

   localparam int          NCNT     = HPM_BASE_IDX + NUM_HPM;
   localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);

   logic [CNT_WIDTH-1:0] cnt [NCNT];
   logic [NCNT-1:0]      inc, wr_lo, wr_hi;
   logic [31:0]          inhibit;
   logic [31:0]          presc;
   logic                 time_tick;

   logic        user_rng, mach_rng, hi_half, cnt_hit, inh_hit;
   logic        eff_write, illegal_c, do_write;
   logic [4:0]  idx;
   logic [63:0] sel_cnt;
   logic [31:0] old_val, new_val;

   assign time_tick = (presc == 32'(TIME_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n)         presc <= '0;
      else if (time_tick) presc <= '0;
      else                presc <= presc + 32'd1;
   end

   always_comb begin
      idx      = csr_addr[4:0];
      hi_half  = csr_addr[7];
      user_rng = ((csr_addr & CNT_RANGE_MASK) == CSR_CYCLE);
      mach_rng = ((csr_addr & CNT_RANGE_MASK) == CSR_MCYCLE);
      inh_hit  = (csr_addr == CSR_MCOUNTINHIBIT);
      // time has no machine alias
      cnt_hit  = (user_rng || (mach_rng && int'(idx) != TIME_IDX)) && (int'(idx) < NCNT);

      sel_cnt = '0;
      for (int k = 0; k < NCNT; k++)
         if (int'(idx) == k) sel_cnt = 64'(cnt[k]);

      if (inh_hit)      old_val = inhibit;
      else if (!cnt_hit) old_val = '0;
      else if (hi_half) old_val = sel_cnt[63:32];
      else              old_val = sel_cnt[31:0];

      eff_write = (csr_op == CSR_OP_RW) ||
                  ((csr_op == CSR_OP_RS || csr_op == CSR_OP_RC) && csr_wdata != '0);
      illegal_c = !(cnt_hit || inh_hit) || (csr_op == CSR_OP_NONE) ||
                  (user_rng && eff_write);
      do_write  = csr_en && !illegal_c && eff_write;

      case (csr_op)
         CSR_OP_RS: new_val = old_val | csr_wdata;
         CSR_OP_RC: new_val = old_val & ~csr_wdata;
         default:   new_val = csr_wdata;
      endcase

      wr_lo = '0;
      wr_hi = '0;
      for (int k = 0; k < NCNT; k++) begin
         wr_lo[k] = do_write && cnt_hit && !hi_half && (int'(idx) == k);
         wr_hi[k] = do_write && cnt_hit &&  hi_half && (int'(idx) == k);
      end

      inc              = '0;
      inc[CYCLE_IDX]   = !inhibit[CYCLE_IDX];
      inc[TIME_IDX]    = time_tick;
      inc[INSTRET_IDX] = instr_retired && !inhibit[INSTRET_IDX];
      for (int i = 0; i < NUM_HPM; i++)
         inc[HPM_BASE_IDX+i] = hpm_event[i] && !inhibit[HPM_BASE_IDX+i];
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                  inhibit <= '0;
      else if (do_write && inh_hit) inhibit <= new_val & INH_MASK;
   end

   for (genvar k = 0; k < NCNT; k++) begin : g_cnt
      riscv_counter64 #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (inc[k]),
         .wr_lo (wr_lo[k]),
         .wr_hi (wr_hi[k]),
         .wdata (new_val),
         .value (cnt[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         csr_rvalid  <= 1'b0;
         csr_rdata   <= '0;
         csr_illegal <= 1'b0;
      end else begin
         csr_rvalid  <= csr_en;
         csr_illegal <= csr_en && illegal_c;
         if (csr_en) csr_rdata <= illegal_c ? 32'h0 : old_val;
      end
   end

endmodule

// File: tb/tb_riscv_csr_counters.sv
module tb_riscv_csr_counters;

   localparam int NH   = 2;
   localparam int TDIV = 4;
   localparam int CW   = 48;
   localparam int NC   = 3 + NH;
   localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;
   localparam logic [31:0]     IMASK = 32'h0000_001D;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        csr_en = 1'b0;
   logic [11:0] csr_addr = '0;
   logic [1:0]  csr_op = '0;
   logic [31:0] csr_wdata = '0;
   logic        csr_rvalid, csr_illegal;
   logic [31:0] csr_rdata;
   logic        instr_retired = 1'b0;
   logic [NH-1:0] hpm_event = '0;

   riscv_csr_counters #(.NUM_HPM(NH), .TIME_DIV(TDIV), .CNT_WIDTH(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .csr_en        (csr_en),
      .csr_addr      (csr_addr),
      .csr_op        (csr_op),
      .csr_wdata     (csr_wdata),
      .csr_rvalid    (csr_rvalid),
      .csr_rdata     (csr_rdata),
      .csr_illegal   (csr_illegal),
      .instr_retired (instr_retired),
      .hpm_event     (hpm_event)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // reference state
   longint unsigned mc [NC];
   logic [31:0]     minh;
   int              mpresc;
   logic [31:0]     mrdata;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: drive request, predict from the reference, clock, compare.
   task automatic cyc(input logic rst, input logic en, input logic [11:0] addr,
                      input logic [1:0] op, input logic [31:0] wd,
                      input logic ret, input logic [NH-1:0] ev);
      int kind, idx, base, a;
      bit hi, usr, effw, ill;
      logic [31:0] oldv, nv;
      longint unsigned nc [NC];
      logic [31:0] ninh;
      int npresc;
      logic e_rv, e_il;
      logic [31:0] e_rd;

      rst_n = rst; csr_en = en; csr_addr = addr; csr_op = op;
      csr_wdata = wd; instr_retired = ret; hpm_event = ev;

      kind = 0; idx = 0; hi = 0; usr = 0; a = int'(addr);
      if (addr == 12'h320) kind = 2;
      for (int u = 0; u < 2; u++)
         for (int h = 0; h < 2; h++) begin
            base = (u == 1 ? 'hC00 : 'hB00) + (h == 1 ? 'h80 : 0);
            if (a >= base && a < base + NC && !(u == 0 && a - base == 1)) begin
               kind = 1; idx = a - base; hi = (h == 1); usr = (u == 1);
            end
         end
      if (kind == 2)      oldv = minh;
      else if (kind == 1) oldv = hi ? 32'(mc[idx] >> 32) : 32'(mc[idx]);
      else                oldv = 0;
      effw = (op == 2'b01) || (op != 2'b00 && wd != 0);
      ill  = (kind == 0) || (op == 2'b00) || (usr && effw);
      case (op)
         2'b10:   nv = oldv | wd;
         2'b11:   nv = oldv & ~wd;
         default: nv = wd;
      endcase

      for (int k = 0; k < NC; k++) nc[k] = mc[k];
      ninh = minh;
      if (!minh[0]) nc[0] = nc[0] + 1;
      npresc = mpresc + 1;
      if (mpresc == TDIV - 1) begin npresc = 0; nc[1] = nc[1] + 1; end
      if (ret && !minh[2]) nc[2] = nc[2] + 1;
      for (int i = 0; i < NH; i++)
         if (ev[i] && !minh[3+i]) nc[3+i] = nc[3+i] + 1;
      if (en && !ill && effw) begin
         if (kind == 1) begin
            if (hi) nc[idx] = {nv, mc[idx][31:0]};
            else    nc[idx] = {mc[idx][63:32], nv};
         end else if (kind == 2) begin
            ninh = nv & IMASK;
         end
      end

      if (!rst) begin
         e_rv = 0; e_il = 0; e_rd = 0;
         for (int k = 0; k < NC; k++) nc[k] = 0;
         ninh = 0; npresc = 0;
      end else if (en) begin
         e_rv = 1; e_il = ill; e_rd = ill ? 32'h0 : oldv;
      end else begin
         e_rv = 0; e_il = 0; e_rd = mrdata;
      end

      @(posedge clk); #1;
      chk("rvalid", csr_rvalid, e_rv);
      chk("illegal", csr_illegal, e_il);
      chk("rdata", csr_rdata, e_rd);

      for (int k = 0; k < NC; k++) mc[k] = nc[k] & CMASK;
      minh = ninh; mpresc = npresc; mrdata = e_rd;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 12'h0, 2'b00, 0, 0, '0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 12'h0, 2'b00, 0, 0, '0);
   endtask

   task automatic acc(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wd);
      cyc(1, 1, addr, op, wd, 0, '0);
   endtask

   logic [11:0] addr_pool [24];

   initial begin
      for (int k = 0; k < NC; k++) mc[k] = 0;
      minh = 0; mpresc = 0; mrdata = 0;
      addr_pool = '{12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82,
                    12'hC03, 12'hC83, 12'hC04, 12'hC84, 12'hC05, 12'hB00,
                    12'hB80, 12'hB01, 12'hB02, 12'hB82, 12'hB03, 12'hB83,
                    12'hB04, 12'hB84, 12'hB05, 12'h320, 12'h321, 12'hC20};
      @(posedge clk); #1;

      do_reset(3);
      idle(10);
      acc(12'hC00, 2'b10, 0);          chk("cycle_lo_10", csr_rdata, 10);
      acc(12'hC80, 2'b10, 0);          chk("cycle_hi_0", csr_rdata, 0);

      acc(12'hB00, 2'b01, 32'hFFFF_FFFF);
      acc(12'hB80, 2'b01, 0);
      idle(1);
      acc(12'hC80, 2'b10, 0);          chk("carry_hi", csr_rdata, 1);
      acc(12'hC00, 2'b10, 0);          chk("carry_lo", csr_rdata, 1);

      acc(12'hC00, 2'b01, 5);          chk("user_rw_ill", csr_illegal, 1);
      acc(12'hC00, 2'b10, 0);          chk("user_rs0_legal", csr_illegal, 0);
      acc(12'hB00, 2'b00, 7);          chk("op00_ill", csr_illegal, 1);

      acc(12'hB80, 2'b01, 32'hFFFF_FFFF);
      acc(12'hB80, 2'b10, 0);          chk("hi_width_mask", csr_rdata, 32'h0000_FFFF);
      acc(12'hB00, 2'b01, 32'hFFFF_FFFF);
      idle(1);
      acc(12'hC80, 2'b10, 0);          chk("wrap_hi", csr_rdata, 0);

      do_reset(2);
      idle(16);
      acc(12'hC01, 2'b10, 0);          chk("time_4", csr_rdata, 4);
      acc(12'hC01, 2'b01, 9);          chk("time_rw_ill", csr_illegal, 1);
      acc(12'hC01, 2'b10, 0);          chk("time_kept", csr_rdata, 4);

      do_reset(2);
      cyc(1, 0, 12'h0, 2'b00, 0, 1, '0);
      cyc(1, 0, 12'h0, 2'b00, 0, 1, '0);
      cyc(1, 1, 12'h320, 2'b10, 4, 1, '0);
      chk("inh_old", csr_rdata, 0);
      cyc(1, 0, 12'h0, 2'b00, 0, 1, '0);
      cyc(1, 0, 12'h0, 2'b00, 0, 1, '0);
      acc(12'hC02, 2'b10, 0);          chk("instret_3", csr_rdata, 3);
      acc(12'h320, 2'b11, 4);          chk("inh_4", csr_rdata, 4);

      do_reset(2);
      for (int i = 0; i < 7; i++) cyc(1, 0, 12'h0, 2'b00, 0, 0, 2'b11);
      acc(12'hC03, 2'b10, 0);          chk("hpm0_7", csr_rdata, 7);
      acc(12'hC04, 2'b10, 0);          chk("hpm1_7", csr_rdata, 7);
      acc(12'hC05, 2'b10, 0);          chk("c05_ill", csr_illegal, 1);
      acc(12'hB05, 2'b10, 0);          chk("b05_ill", csr_illegal, 1);
      for (int i = 0; i < 3; i++) cyc(1, 0, 12'h0, 2'b00, 0, 0, 2'b11);
      cyc(0, 1, 12'hC03, 2'b10, 0, 0, 2'b11);
      chk("rvalid_in_reset", csr_rvalid, 0);
      do_reset(1);
      acc(12'hC03, 2'b10, 0);          chk("hpm0_after_rst", csr_rdata, 0);

      for (int i = 0; i < 3000; i++) begin
         logic [11:0] ad;
         logic [31:0] wd;
         case ($urandom_range(0, 3))
            0:       wd = 0;
            1:       wd = $urandom_range(0, 31);
            default: wd = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) ad = 12'($urandom);
         else ad = addr_pool[$urandom_range(0, 23)];
         cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7), ad,
             2'($urandom_range(0, 3)), wd, 1'($urandom), NH'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
